// File: rtl/mul_dispatch.sv
// Operand FIFO feeding a Booth multiplier: resets, starts and waits on the multiplier per job,
// returns products through a ready/valid port and abandons jobs that exceed a cycle budget.
module mul_dispatch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_a,
    input  logic [7:0]             in_b,
    output logic                   mul_reset,
    output logic                   mul_start,
    output logic [7:0]             mul_multiplier,
    output logic [7:0]             mul_multiplicand,
    input  logic [16:0]            mul_product,
    input  logic                   mul_done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [16:0]            res_product,
    output logic                   err_timeout,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StMrst, StIssue, StWait, StHold} state_e;

    state_e        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          res_valid_q, res_valid_d;
    logic [16:0]   res_product_q, res_product_d;
    logic          err_q, err_d;
    logic          push, pop, full, empty;

    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !reset && !full;
    assign push     = in_valid && in_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        cnt_d         = cnt_q;
        res_valid_d   = res_valid_q;
        res_product_d = res_product_q;
        err_d         = err_q;
        mul_start     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty && !res_valid_q) begin
                    pop     = 1'b1;
                    state_d = StMrst;
                end
            end
            StMrst: state_d = StIssue;
            StIssue: begin
                mul_start = 1'b1;
                cnt_d     = '0;
                state_d   = StWait;
            end
            StWait: begin
                mul_start = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (mul_done) begin
                    res_product_d = mul_product;
                    res_valid_d   = 1'b1;
                    state_d       = StHold;
                // The ISSUE cycle is the first of the TIMEOUT start cycles.
                end else if (cnt_d == CW'(TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StMrst;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHold: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            op_a_d = mem_q[rd_ptr_q][15:8];
            op_b_d = mem_q[rd_ptr_q][7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            cnt_q         <= '0;
            res_valid_q   <= 1'b0;
            res_product_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q      <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q       <= count_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            cnt_q         <= cnt_d;
            res_valid_q   <= res_valid_d;
            res_product_q <= res_product_d;
            err_q         <= err_d;
        end
    end

    assign mul_reset        = reset || (state_q == StMrst);
    assign mul_multiplier   = op_a_q;
    assign mul_multiplicand = op_b_q;
    assign res_valid        = res_valid_q;
    assign res_product      = res_product_q;
    assign err_timeout      = err_q;
    assign pending          = count_q;

endmodule

// File: tb/tb_mul_dispatch.sv
// Bench for mul_dispatch: behavioural Booth multiplier on the downstream side, product queue
// reference model computed with plain arithmetic, one task per scenario.
module tb_mul_dispatch;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 40;
    localparam int PW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_a = '0;
    logic [7:0]    in_b = '0;
    logic          mul_reset, mul_start;
    logic [7:0]    mul_multiplier, mul_multiplicand;
    logic [16:0]   mul_product = '0;
    logic          mul_done = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [16:0]   res_product;
    logic          err_timeout;
    logic [PW-1:0] pending;

    int n_cmp = 0, n_bad = 0, cyc = 0, push_idx = 0, drop_idx = -1, rv_cycles = 0;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];

    mul_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_b(in_b), .mul_reset(mul_reset), .mul_start(mul_start),
        .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
        .mul_product(mul_product), .mul_done(mul_done), .res_valid(res_valid),
        .res_ready(res_ready), .res_product(res_product), .err_timeout(err_timeout),
        .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] booth(input logic [7:0] a, input logic [7:0] b);
        int acc = 0;
        int m = int'($signed(b));
        logic prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (a[i] && !prev) acc = acc - m * (1 << i);
            if (!a[i] && prev) acc = acc + m * (1 << i);
            prev = a[i];
        end
        return acc[16:0];
    endfunction

    function automatic logic [16:0] ref_product(input logic [7:0] a, input logic [7:0] b);
        int p = int'($signed(a)) * int'($signed(b));
        return p[16:0];
    endfunction

    // Downstream multiplier: done clears only on mul_reset; a dropped job never finishes.
    logic m_busy = 1'b0, m_drop = 1'b0;
    int m_lat = 0, m_start_idx = 0;
    logic [7:0] m_a = '0, m_b = '0;
    always @(posedge clk) begin
        if (reset) begin
            mul_done <= 1'b0; m_busy <= 1'b0; m_start_idx <= 0;
        end else if (mul_reset) begin
            mul_done <= 1'b0; m_busy <= 1'b0;
        end else if (mul_start && !m_busy && !mul_done) begin
            m_busy      <= 1'b1;
            m_drop      <= (m_start_idx == drop_idx);
            m_start_idx <= m_start_idx + 1;
            m_lat       <= int'($urandom_range(5, 0));
            m_a         <= mul_multiplier;
            m_b         <= mul_multiplicand;
            mul_product <= 17'($urandom);
        end else if (m_busy && !m_drop) begin
            if (m_lat == 0) begin
                mul_done <= 1'b1; m_busy <= 1'b0; mul_product <= booth(m_a, m_b);
            end else begin
                m_lat <= m_lat - 1;
            end
        end
    end

    task automatic step();
        if (in_valid && in_ready) begin
            if (push_idx != drop_idx) exp_q.push_back(ref_product(in_a, in_b));
            push_idx++;
        end
        if (res_valid) rv_cycles++;
        if (res_valid && res_ready) got_q.push_back(res_product);
        @(negedge clk);
        cyc++;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        in_a = a; in_b = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic clear_model();
        exp_q.delete(); got_q.delete(); rv_cycles = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1;
        step(); step();
        n_cmp++;
        if ({in_ready, mul_reset, mul_start, res_valid, err_timeout} !== 5'b01000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 01000",
                     {in_ready, mul_reset, mul_start, res_valid, err_timeout});
        end
        n_cmp++;
        if ({mul_multiplier, mul_multiplicand, res_product, pending} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h/%h/%h/%0d want all 0",
                     mul_multiplier, mul_multiplicand, res_product, pending);
        end
        reset = 1'b0; in_valid = 1'b0; push_idx = 0; drop_idx = -1;
        clear_model();
        step();
        n_cmp++;
        if ({in_ready, mul_reset, pending} !== {2'b10, PW'(0)}) begin
            n_bad++;
            $display("FAIL reset_release: got rdy=%b mrst=%b pend=%0d want 1 0 0",
                     in_ready, mul_reset, pending);
        end
    endtask

    task automatic test_single();
        int pc, s = -1, d = -1, r = -1, n_mr = 0;
        clear_model(); res_ready = 1'b1;
        pc = cyc;
        push(8'hF6, 8'd11);
        for (int i = 0; i < 40; i++) begin
            if (mul_reset) n_mr++;
            if (mul_start && s < 0) s = cyc;
            if (mul_done && d < 0) d = cyc;
            if (res_valid && r < 0) r = cyc;
            step();
        end
        n_cmp++;
        if (s != pc + 3) begin
            n_bad++; $display("FAIL single_start_latency: got %0d want %0d", s - pc, 3);
        end
        n_cmp++;
        if (n_mr != 1) begin
            n_bad++; $display("FAIL single_mul_reset_pulses: got %0d want 1", n_mr);
        end
        n_cmp++;
        if (d < 0 || r != d + 1) begin
            n_bad++; $display("FAIL single_res_latency: got done=%0d valid=%0d want +1", d, r);
        end
        n_cmp++;
        if (rv_cycles != 1 || got_q.size() != 1) begin
            n_bad++;
            $display("FAIL single_count: got %0d valid cycles %0d results want 1 1",
                     rv_cycles, got_q.size());
        end else begin
            n_cmp++;
            if (got_q[0] !== 17'h1FF92) begin
                n_bad++; $display("FAIL single_product: got %h want 1ff92", got_q[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a_tab[4] = '{8'd14, 8'd24, 8'd76, 8'd101};
        logic [7:0] b_tab[4] = '{8'd13, 8'd34, 8'd98, 8'd102};
        logic [16:0] hp;
        int w = 0;
        clear_model(); res_ready = 1'b0;
        push(8'd3, 8'hFB);
        while (!res_valid && w < 30) begin step(); w++; end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++; $display("FAIL fill_accept_%0d: got %b want 1", i, in_ready);
            end
            push(a_tab[i], b_tab[i]);
        end
        n_cmp++;
        if (pending !== PW'(4) || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL fill_full: got pend=%0d rdy=%b want 4 0", pending, in_ready);
        end
        push(8'd7, 8'd7);
        hp = res_product;
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if ({res_valid, mul_start, pending, res_product} !== {2'b10, PW'(4), hp}) begin
                n_bad++;
                $display("FAIL hold_stable_%0d: got v=%b st=%b pend=%0d prod=%h want 1 0 4 %h",
                         i, res_valid, mul_start, pending, res_product, hp);
            end
            step();
        end
        res_ready = 1'b1; w = 0;
        while (got_q.size() < 5 && w < 200) begin step(); w++; end
        n_cmp++;
        if (got_q.size() != 5 || exp_q.size() != 5) begin
            n_bad++;
            $display("FAIL fill_result_count: got %0d want 5 (model %0d)", got_q.size(),
                     exp_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL fill_order_%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int s = -1, e = -1;
        clear_model(); res_ready = 1'b1;
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_bad++; $display("FAIL timeout_pre: got %b want 0", err_timeout);
        end
        drop_idx = push_idx;
        push(8'd9, 8'hFE);
        push(8'd20, 8'd30);
        for (int i = 0; i < TIMEOUT + 40; i++) begin
            if (mul_start && s < 0) s = cyc;
            if (err_timeout && e < 0) e = cyc;
            step();
        end
        n_cmp++;
        if (s < 0 || e < 0 || e - s != TIMEOUT) begin
            n_bad++; $display("FAIL timeout_delay: got %0d want %0d", e - s, TIMEOUT);
        end
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++; $display("FAIL timeout_results: got %0d want 1", got_q.size());
        end else begin
            n_cmp++;
            if (got_q[0] !== exp_q[0]) begin
                n_bad++; $display("FAIL timeout_job2: got %h want %h", got_q[0], exp_q[0]);
            end
        end
        n_cmp++;
        if (err_timeout !== 1'b1) begin
            n_bad++; $display("FAIL timeout_sticky: got %b want 1", err_timeout);
        end
        drop_idx = -1;
    endtask

    task automatic test_stream();
        int n = 0, coinc = 0, w = 0, p0;
        logic pu, hs, hs_prev = 1'b0;
        clear_model(); res_ready = 1'b1;
        while (got_q.size() < 10 && w < 400) begin
            in_valid = (n < 10) && (pending < PW'(2) || (hs_prev && pending == PW'(2)));
            in_a = 8'($urandom); in_b = 8'($urandom);
            p0 = int'(pending); pu = in_valid && in_ready; hs = res_valid && res_ready;
            step();
            if (pu) n++;
            n_cmp++;
            if (int'(pending) != p0 + int'(pu) - int'(mul_reset)) begin
                n_bad++;
                $display("FAIL stream_occupancy: got %0d want %0d", pending,
                         p0 + int'(pu) - int'(mul_reset));
            end
            if (pu && mul_reset && p0 == 2) coinc++;
            hs_prev = hs; w++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (coinc == 0) begin
            n_bad++; $display("FAIL stream_push_pop_at_2: got %0d want >0", coinc);
        end
        n_cmp++;
        if (got_q.size() != 10 || exp_q.size() != 10) begin
            n_bad++; $display("FAIL stream_count: got %0d want 10", got_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL stream_order_%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int w = 0;
        clear_model(); res_ready = 1'b1;
        drop_idx = push_idx;
        for (int i = 0; i < 4; i++) push(8'(i + 1), 8'(i + 5));
        while (!(mul_start && pending == PW'(3)) && w < 20) begin step(); w++; end
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if ({mul_start, pending} !== {1'b1, PW'(3)}) begin
            n_bad++; $display("FAIL midreset_setup: got st=%b pend=%0d want 1 3", mul_start, pending);
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if ({pending, mul_start, res_valid, err_timeout} !== '0) begin
            n_bad++;
            $display("FAIL midreset_flush: got pend=%0d st=%b v=%b err=%b want 0 0 0 0",
                     pending, mul_start, res_valid, err_timeout);
        end
        reset = 1'b0; push_idx = 0; drop_idx = -1;
        clear_model();
        for (int i = 0; i < 60; i++) step();
        n_cmp++;
        if (rv_cycles != 0 || got_q.size() != 0 || err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_stray: got %0d valid cycles err=%b want 0 0", rv_cycles,
                     err_timeout);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_timeout();
        test_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_dispatch.md
MUL_DISPATCH -- requirements
Module: mul_dispatch

Interface
REQ-001 Parameter DEPTH, default 4: operand-FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 40: max cycles from mul_start rise to mul_done before the job is abandoned.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid / in_ready  in / out  1 / 1  operand-push handshake; a transfer occurs on a cycle where both are 1.
REQ-006 in_a / in_b  in  8 / 8  multiplier / multiplicand, two's complement.
REQ-007 mul_reset  out  1  reset to the downstream Booth multiplier.
REQ-008 mul_start  out  1  start to the multiplier.
REQ-009 mul_multiplier / mul_multiplicand  out  8 / 8  operands to the multiplier, held stable while mul_start=1.
REQ-010 mul_product / mul_done  in  17 / 1  result and completion from the multiplier.
REQ-011 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-012 res_product  out  17  captured mul_product, unmodified.
REQ-013 err_timeout  out  1  sticky timeout flag.
REQ-014 pending  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 The FIFO SHALL accept a push when not full; in_ready = !full, registered-free (combinational from occupancy).
REQ-016 Simultaneous push and pop on a full FIFO SHALL be refused (in_ready=0); on a non-full, non-empty FIFO both SHALL occur, occupancy unchanged.
REQ-017 Read/write pointers SHALL wrap modulo DEPTH; the occupancy counter disambiguates full from empty.
REQ-018 The FSM SHALL have states IDLE, MRST, ISSUE, WAIT, HOLD.
REQ-019 IDLE: if FIFO non-empty and res_valid=0 -> pop the head into the operand register and go to MRST.
REQ-020 MRST: mul_reset=1 for exactly one cycle -> ISSUE (the multiplier only clears done on reset).
REQ-021 ISSUE: mul_start=1, zero the timeout counter -> WAIT.
REQ-022 WAIT: mul_start SHALL stay 1; the counter increments each cycle; on mul_done=1, capture mul_product into res_product, set res_valid=1 -> HOLD.
REQ-023 WAIT: if the counter reaches TIMEOUT without mul_done, set err_timeout, drop the job (no res_valid) -> MRST with the next head, or -> IDLE if the FIFO is empty.
REQ-024 HOLD: mul_start=0; when res_valid and res_ready are both 1, clear res_valid -> IDLE.
REQ-025 mul_done sampled in any state other than WAIT SHALL be ignored.
REQ-026 res_product and res_valid SHALL remain stable while res_valid=1 and res_ready=0.
REQ-027 Latency: from a push into an empty FIFO with an idle block, mul_start SHALL rise at cycle +3; res_valid SHALL rise 1 cycle after mul_done is first seen.
REQ-028 Job order SHALL be FIFO order; each accepted job yields one result, except a timed-out job, which yields none.
REQ-029 err_timeout SHALL clear only on reset.

Reset
REQ-030 While reset=1, the block SHALL go to IDLE and empty the FIFO; outputs SHALL be: in_ready=0, mul_reset=1, mul_start=0, mul_multiplier=0, mul_multiplicand=0, res_valid=0, res_product=0, err_timeout=0, pending=0.
REQ-031 After reset deasserts, outputs SHALL take their idle values: in_ready=1 and mul_reset=0.
REQ-032 A reset asserted mid-job (any state) SHALL discard the in-flight job and all queued jobs, with no res_valid afterward.

Verification
REQ-033 Push (a=-10, b=11) with res_ready=1 and a behavioural Booth model -> one mul_reset pulse, then mul_start; res_product matches the model's output for -110, exactly one res_valid.
REQ-034 Push 4 pairs (14,13), (24,34), (76,98), (101,102) back-to-back with DEPTH=4 -> all accepted, pending=4, 5th push refused; results emerge in push order.
REQ-035 Hold res_ready=0 for 20 cycles after the first result -> res_product is stable, the next job does not issue, and pending stays constant.
REQ-036 Model never asserts mul_done for job 1 of 2 -> err_timeout=1 exactly TIMEOUT cycles after mul_start; job 2 still completes and returns one result.
REQ-037 Assert reset during WAIT with 3 jobs queued -> next cycle pending=0, mul_start=0, res_valid=0; no stray result after release.
REQ-038 Push and pop in the same cycle with occupancy 2 -> occupancy stays 2 and pointers wrap correctly across 10 jobs.
